// File: rtl/ftu_pkg.sv
// Shared types and elaboration-time helpers for the folded threshold unit.
package ftu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic MODE_MAJ = 1'b0;
    localparam logic MODE_THR = 1'b1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Smallest count that is a strict majority of n bits.
    function automatic int maj_thr(input int n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/folded_threshold_unit_popcount.sv
// Purely combinational population count of a W-bit word.
module popcount_w #(
    parameter  int W  = 8,
    localparam int PW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [PW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + PW'(data_i[i]);
        end
    end

endmodule

// File: rtl/folded_threshold_unit.sv
// Folded threshold gate: accumulates the popcount of an N-bit vector received
// as W-bit beats and emits a majority or programmable-threshold decision.
module folded_threshold_unit
    import ftu_pkg::*;
#(
    parameter  int N     = 59,
    parameter  int W     = 8,
    localparam int BEATS = ceil_div(N, W),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             mode,
    input  logic [CNT_W-1:0] thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic [CNT_W-1:0] out_count
);

    localparam int LAST_BITS = N - (BEATS - 1) * W;
    localparam int BC_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PC_W      = $clog2(W + 1);

    localparam logic [W-1:0]     LAST_MASK = {W{1'b1}} >> (W - LAST_BITS);
    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] MAJ_COUNT = CNT_W'(maj_thr(N));

    state_e           state_q, state_d;
    logic [BC_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             accept;
    logic             first_beat;
    logic             last_beat;
    logic [W-1:0]     beat_data;
    logic [PC_W-1:0]  beat_ones;
    logic [CNT_W-1:0] sum;
    logic             eff_mode;
    logic [CNT_W-1:0] eff_thr;
    logic             decision;

    // While a result is held, the next vector may only start as the sink takes it.
    assign in_ready   = (state_q == HOLD) ? out_ready : 1'b1;
    assign accept     = in_valid && in_ready;
    assign first_beat = (beat_q == '0);
    assign last_beat  = (beat_q == LAST_BEAT);

    // Unaccepted beats are forced to zero so an undriven bus never reaches the sum.
    assign beat_data = !accept   ? '0 :
                       last_beat ? (in_data & LAST_MASK) : in_data;

    popcount_w #(.W(W)) u_popcount (
        .data_i  (beat_data),
        .count_o (beat_ones)
    );

    assign sum = (first_beat ? '0 : acc_q) + CNT_W'(beat_ones);

    // A single-beat vector decides on the same beat that supplies mode/thr.
    assign eff_mode = first_beat ? mode : mode_q;
    assign eff_thr  = first_beat ? thr  : thr_q;
    assign decision = (eff_mode == MODE_THR) ? (sum >= eff_thr) : (sum >= MAJ_COUNT);

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        y_d     = y_q;
        count_d = count_q;

        if (accept) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            acc_d  = sum;
            if (first_beat) begin
                mode_d = mode;
                thr_d  = thr;
            end
            if (last_beat) begin
                y_d     = decision;
                count_d = sum;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = last_beat ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (accept && last_beat) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) state_d = last_beat ? HOLD : ACCUM;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            acc_q   <= '0;
            mode_q  <= MODE_MAJ;
            thr_q   <= '0;
            y_q     <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
            y_q     <= y_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_y     = y_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_folded_threshold_unit.sv
// Directed and randomised checks of folded_threshold_unit at N=59, W=8.
module tb_folded_threshold_unit;

    localparam int N     = 59;
    localparam int W     = 8;
    localparam int BEATS = 8;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_data = '0;
    logic             mode = 1'b0;
    logic [CNT_W-1:0] thr = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_y;
    logic [CNT_W-1:0] out_count;

    folded_threshold_unit #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .thr       (thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    typedef struct {
        logic [63:0] v;
        logic        m;
        logic [5:0]  t;
        int          cnt;
        logic        y;
    } vec_t;

    typedef struct {
        int   cnt;
        logic y;
    } res_t;

    res_t exp_q[$];
    bit   mon_en    = 1'b0;
    bit   rand_done = 1'b0;

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input logic [7:0] d, input logic m, input logic [5:0] t);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        thr      = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("beat_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Later beats carry inverted mode/thr so only the first-beat values may matter.
    task automatic send_vector(input logic [63:0] v, input logic m, input logic [5:0] t,
                               input bit gaps, input bit chk_early);
        for (int k = 0; k < BEATS; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(v[k*8 +: 8], (k == 0) ? m : ~m, (k == 0) ? t : ~t);
            if (chk_early && k == BEATS - 2) check("early_valid", out_valid, 0);
        end
    endtask

    task automatic check_result(input string tag, input int cnt, input logic y);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_count"}, out_count, cnt);
        check({tag, "_y"}, out_y, y);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("rand_count", out_count, e.cnt);
                check("rand_y", out_y, e.y);
            end
        end
    end

    vec_t dir [9] = '{
        '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd0,  59, 1'b1},
        '{64'h0000_0000_3FFF_FFFF, 1'b0, 6'd0,  30, 1'b1},
        '{64'h0000_0000_1FFF_FFFF, 1'b0, 6'd0,  29, 1'b0},
        '{64'hF800_0000_0000_0000, 1'b0, 6'd0,   0, 1'b0},
        '{64'h0700_0000_0000_0000, 1'b0, 6'd0,   3, 1'b0},
        '{64'h0000_0000_0000_03FF, 1'b1, 6'd10, 10, 1'b1},
        '{64'h0000_0000_0000_03FF, 1'b1, 6'd11, 10, 1'b0},
        '{64'h0000_0000_0000_03FF, 1'b1, 6'd0,  10, 1'b1},
        '{64'h0000_0000_0000_03FF, 1'b1, 6'd63, 10, 1'b0}
    };

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_count", out_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            send_vector(dir[i].v, dir[i].m, dir[i].t, 1'b0, i == 0);
            check_result($sformatf("dir%0d", i), dir[i].cnt, dir[i].y);
        end

        // Sink stalls on an all-ones result while the next first beat waits.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_vector(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'd0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        mode     = 1'b0;
        thr      = 6'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_count", out_count, 59);
            check("stall_y", out_y, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        check("handoff_valid", out_valid, 0);
        for (int k = 1; k < BEATS; k++) begin
            send_beat((k == BEATS - 1) ? 8'h07 : 8'h00, 1'b1, 6'd0);
        end
        check_result("handoff", 11, 1'b0);

        // Reset in the middle of a vector discards the partial sum.
        for (int k = 0; k < 5; k++) send_beat(8'hFF, 1'b0, 6'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_count", out_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("postrst_valid", out_valid, 0);
        send_vector(64'h0101_0101_0101_0101, 1'b0, 6'd0, 1'b0, 1'b0);
        check_result("postrst", 8, 1'b0);
        @(posedge clk);
        #1;

        // Random vectors, random input gaps and random sink backpressure.
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [63:0] v;
                    logic        m;
                    logic [5:0]  t;
                    res_t        e;
                    v = {$urandom, $urandom};
                    if (i % 3 == 0) v = v & {$urandom, $urandom};
                    m = 1'($urandom_range(0, 1));
                    t = 6'($urandom_range(0, 63));
                    e.cnt = $countones(v[N-1:0]);
                    e.y   = m ? (e.cnt >= int'(t)) : (e.cnt >= 30);
                    exp_q.push_back(e);
                    send_vector(v, m, t, 1'b1, 1'b0);
                end
                for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        check("sb_drain", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
